md_unit: RTL and testbench

- Multiply/divide responder for the five-stage MIPS pipeline.
- Sits beside the ALU in EX and owns the HI/LO registers.
- The pipeline initiates operations with a one-cycle start; md_unit answers with busy/state, which the hazard unit uses to stall dependent mult/div/mf/mt instructions.
- Multi-cycle latency models a real iterative datapath.

---
 rtl/md_unit.sv | 138 +++++++++++++
 tb/tb_md_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide responder for the five-stage MIPS pipeline.
// Owns the architectural HI/LO registers. Mult/div results are computed at
// accept into shadow registers and committed after a fixed busy period that
// models an iterative datapath. MTHI/MTLO write HI/LO in a single cycle.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset, clears all state
//   start   one-cycle issue strobe from EX
//   md_op   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   rs_val  dividend / multiplicand / MT source
//   rt_val  divisor / multiplier
//   hi_o    architectural HI
//   lo_o    architectural LO
//   busy    registered, high while a mult/div is in flight
//   state   combinational stall request: issuing mult/div, or busy
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy,
  output logic        state
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  logic [CW-1:0] counter;
  logic [31:0]   shadowHi;
  logic [31:0]   shadowLo;
  logic          shadowWrite;

  logic          isMulDiv;
  logic [63:0]   product;
  logic [31:0]   divQ;
  logic [31:0]   divR;

  assign isMulDiv = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign state    = (start && isMulDiv) || busy;

  // Signed multiply via sign-extended 64-bit operands; the low 64 bits of the
  // product are the exact two's-complement result.
  always_comb begin
    product = '0;
    if (md_op == OP_MULT)
      product = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    else
      product = {32'b0, rs_val} * {32'b0, rt_val};
  end

  // Signed divide is done on magnitudes so that 0x80000000 / -1 never hits a
  // native signed overflow; its magnitude quotient 0x80000000 is already the
  // wrapped architectural result. A zero divisor is replaced by 1 purely to
  // keep the datapath defined; the result is discarded at commit anyway.
  logic        signedDiv;
  logic        negQ;
  logic        negR;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] magQ;
  logic [31:0] magR;

  always_comb begin
    signedDiv = (md_op == OP_DIV);
    negQ      = signedDiv && (rs_val[31] ^ rt_val[31]);
    negR      = signedDiv && rs_val[31];
    absA      = (signedDiv && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    absB      = (signedDiv && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    if (absB == '0)
      absB = 32'd1;
    magQ = absA / absB;
    magR = absA % absB;
    divQ = negQ ? (32'd0 - magQ) : magQ;
    divR = negR ? (32'd0 - magR) : magR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_o        <= '0;
      lo_o        <= '0;
      busy        <= 1'b0;
      counter     <= '0;
      shadowHi    <= '0;
      shadowLo    <= '0;
      shadowWrite <= 1'b0;
    end else if (busy) begin
      // Starts presented while busy are ignored entirely.
      if (counter == CW'(1)) begin
        if (shadowWrite) begin
          hi_o <= shadowHi;
          lo_o <= shadowLo;
        end
        busy        <= 1'b0;
        counter     <= '0;
        shadowWrite <= 1'b0;
      end else begin
        counter <= counter - 1'b1;
      end
    end else if (start) begin
      case (md_op)
        OP_MULT, OP_MULTU: begin
          shadowHi    <= product[63:32];
          shadowLo    <= product[31:0];
          shadowWrite <= 1'b1;
          counter     <= CW'(MULT_CYCLES);
          busy        <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          shadowHi    <= divR;
          shadowLo    <= divQ;
          shadowWrite <= (rt_val != '0);
          counter     <= CW'(DIV_CYCLES);
          busy        <= 1'b1;
        end
        OP_MTHI: hi_o <= rs_val;
        OP_MTLO: lo_o <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;
  logic        state;

  int total;
  int bad;
  logic allowOverlap;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_o   (hi_o),
    .lo_o   (lo_o),
    .busy   (busy),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol watch: the stall unit must never present start while busy.
  always @(negedge clk) begin
    if (!reset && start && busy && !allowOverlap) begin
      bad++;
      $display("FAIL protocol: start=%0b while busy=%0b", start, busy);
    end
  end

  // Issue a mult/div and check state, busy length and the committed result.
  task automatic runOp(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int expCycles, input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int cnt;
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    #1;
    total++;
    if (state !== 1'b1) begin
      bad++; $display("FAIL %s_state: got %0b want 1", name, state);
    end
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    total++;
    if (cnt !== expCycles) begin
      bad++; $display("FAIL %s_busy: got %0d cycles want %0d", name, cnt, expCycles);
    end
    total++;
    if (hi_o !== expHi) begin
      bad++; $display("FAIL %s_hi: got %h want %h", name, hi_o, expHi);
    end
    total++;
    if (lo_o !== expLo) begin
      bad++; $display("FAIL %s_lo: got %h want %h", name, lo_o, expLo);
    end
  endtask

  task automatic mtOp(input string name, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] expHi, input logic [31:0] expLo);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = 32'h0;
    #1;
    total++;
    if (state !== 1'b0) begin
      bad++; $display("FAIL %s_state: got %0b want 0", name, state);
    end
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    total++;
    if (busy !== 1'b0 || hi_o !== expHi || lo_o !== expLo) begin
      bad++; $display("FAIL %s: busy=%0b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                      name, busy, hi_o, lo_o, expHi, expLo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0 || state !== 1'b0) begin
      bad++; $display("FAIL reset: busy=%0b hi=%h lo=%h state=%0b want all 0",
                      busy, hi_o, lo_o, state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    runOp("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    runOp("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
  endtask

  task automatic test_div();
    runOp("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
  endtask

  task automatic test_divzero();
    mtOp("mthi", 3'd5, 32'h1234, 32'h1234, 32'h80000000);
    mtOp("mtlo", 3'd6, 32'h5678, 32'h1234, 32'h5678);
    runOp("divu_zero", 3'd4, 32'd5, 32'd0, 10, 32'h1234, 32'h5678);
  endtask

  task automatic test_back_to_back();
    runOp("divu_a", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    runOp("mult_b", 3'd1, 32'd7, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFF9);
  endtask

  task automatic test_none();
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi_o; l0 = lo_o;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1; md_op = (i == 0) ? 3'd0 : 3'd7; rs_val = 32'hFFFF; rt_val = 32'd3;
      #1;
      total++;
      if (state !== 1'b0) begin
        bad++; $display("FAIL none_state: op=%0d got %0b want 0", md_op, state);
      end
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || hi_o !== h0 || lo_o !== l0) begin
        bad++; $display("FAIL none_effect: busy=%0b hi=%h lo=%h want 0 %h %h",
                        busy, hi_o, lo_o, h0, l0);
      end
    end
    md_op = 3'd0;
  endtask

  task automatic test_ignored_start();
    int cnt;
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    cnt = 0;
    if (busy === 1'b1) cnt = 1;
    allowOverlap = 1'b1;
    @(negedge clk);
    start = 1'b1; md_op = 3'd6; rs_val = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    allowOverlap = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    total++;
    if (cnt !== 5) begin
      bad++; $display("FAIL ignored_busy: got %0d cycles want 5", cnt);
    end
    total++;
    if (lo_o !== 32'd6 || hi_o !== 32'd0) begin
      bad++; $display("FAIL ignored_result: hi=%h lo=%h want 0 6", hi_o, lo_o);
    end
  endtask

  task automatic test_reset_midop();
    mtOp("pre_mthi", 3'd5, 32'hAAAA, 32'hAAAA, 32'd6);
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      bad++; $display("FAIL reset_mid: busy=%0b hi=%h lo=%h want all 0", busy, hi_o, lo_o);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      bad++; $display("FAIL reset_nocommit: busy=%0b hi=%h lo=%h want all 0",
                      busy, hi_o, lo_o);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    allowOverlap = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_back_to_back();
    test_none();
    test_ignored_start();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1);
  end

endmodule
